// File: rtl/absmax_pkg.sv
// Shared types and the magnitude helper for the absmax frame scheduler.
package absmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int W_DEF = 4;
  localparam int MAG_W = 32;

  // Callers sign-extend into MAG_W and keep the low W bits, so -2^(W-1)
  // comes back as 2^(W-1) without saturation.
  function automatic logic [MAG_W-1:0] abs_mag(
    input logic signed [MAG_W-1:0] x
  );
    return x[MAG_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/absmax_cmp.sv
// Shared magnitude comparator: candidate magnitude and strict-greater flag.
module absmax_cmp
  import absmax_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] i_cand,
  input  logic [W-1:0] i_best_mag,
  output logic [W-1:0] o_cand_mag,
  output logic         o_take_new
);

  assign o_cand_mag = W'(abs_mag(MAG_W'(signed'(i_cand))));
  assign o_take_new = o_cand_mag > i_best_mag;

endmodule

// File: rtl/absmax_frame_sched.sv
// Frame scheduler emitting each frame's largest-magnitude sample.
// Define ABSMAX_FRAME_SCHED_IDX_EN to add the out_idx winner-position port.
module absmax_frame_sched
  import absmax_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int FRAME_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   in_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_data,
  output logic [W-1:0]                   out_mag,
  output logic [$clog2(FRAME_LEN+1)-1:0] out_cnt
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
  ,
  output logic [$clog2(FRAME_LEN)-1:0]   out_idx
`endif
);

  localparam int CW = $clog2(FRAME_LEN+1);
  localparam int IW = $clog2(FRAME_LEN);

  state_t r_state;
  state_t w_state_nxt;

  logic          r_in_ready;
  logic [W-1:0]  r_best_data;
  logic [W-1:0]  r_best_mag;
  logic [CW-1:0] r_cnt;
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
  logic [IW-1:0] r_best_idx;
`endif

  logic          w_acc;
  logic [W-1:0]  w_mag;
  logic          w_take;
  logic [CW-1:0] w_cnt_inc;

  assign w_acc     = in_valid & r_in_ready;
  assign w_cnt_inc = r_cnt + CW'(1);

  absmax_cmp #(
    .W(W)
  ) u_cmp (
    .i_cand     (in_data),
    .i_best_mag (r_best_mag),
    .o_cand_mag (w_mag),
    .o_take_new (w_take)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (w_acc) w_state_nxt = ACCUM;
      ACCUM:
        if (flush || (w_acc && w_cnt_inc == CW'(FRAME_LEN)))
          w_state_nxt = EMIT;
      EMIT:
        if (out_ready) w_state_nxt = IDLE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  // in_ready is registered so it stays low through reset and the EMIT window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_best_data <= '0;
      r_best_mag  <= '0;
      r_cnt       <= '0;
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
      r_best_idx  <= '0;
`endif
    end else begin
      r_in_ready <= (w_state_nxt != EMIT);
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_best_data <= in_data;
            r_best_mag  <= w_mag;
            r_cnt       <= CW'(1);
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
            r_best_idx  <= '0;
`endif
          end
        end
        ACCUM: begin
          if (w_acc) begin
            r_cnt <= w_cnt_inc;
            if (w_take) begin
              r_best_data <= in_data;
              r_best_mag  <= w_mag;
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
              r_best_idx  <= IW'(r_cnt);
`endif
            end
          end
        end
        EMIT: begin
          if (out_ready) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == EMIT);
  assign out_data  = r_best_data;
  assign out_mag   = r_best_mag;
  assign out_cnt   = r_cnt;
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
  assign out_idx   = r_best_idx;
`endif

endmodule

// File: tb/tb_absmax_frame_sched.sv
// Scoreboard bench for absmax_frame_sched with directed frames.
module tb_absmax_frame_sched;

  localparam int W  = 4;
  localparam int FL = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_mag;
  logic [3:0]   out_cnt;
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
  logic [2:0]   out_idx;
`endif

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] m;
    logic [3:0] c;
    logic [2:0] i;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  absmax_frame_sched #(
    .W(W),
    .FRAME_LEN(FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mag   (out_mag),
    .out_cnt   (out_cnt)
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got data %0h want no output",
                 out_data);
      end else begin
        e_mon = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e_mon.d));
        chk("out_mag", 32'(out_mag), 32'(e_mon.m));
        chk("out_cnt", 32'(out_cnt), 32'(e_mon.c));
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
        chk("out_idx", 32'(out_idx), 32'(e_mon.i));
`endif
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic fl);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] v, input int n,
                           input logic fl_last, input exp_t e,
                           input logic push);
    if (push) q.push_back(e);
    for (int i = 0; i < n; i++)
      send(v[4*i +: 4], fl_last && (i == n - 1));
    if (n == FL || fl_last)
      chk("latency_valid", 32'(out_valid), 32'd1);
  endtask

  logic [3:0] hold_d, hold_m, hold_c;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_frame(32'hE40A_52D1, 8, 1'b0, '{4'hA, 4'd6, 4'd8, 3'd4}, 1'b1);
    run_frame(32'h0001_23D3, 8, 1'b0, '{4'h3, 4'd3, 4'd8, 3'd0}, 1'b1);
    run_frame(32'h0000_0087, 8, 1'b0, '{4'h8, 4'd8, 4'd8, 3'd1}, 1'b1);

    run_frame(32'h0000_00B2, 2, 1'b0, '{4'hB, 4'd5, 4'd2, 3'd1}, 1'b1);
    do_flush();
    chk("flush_valid", 32'(out_valid), 32'd1);
    run_frame(32'h0000_06B2, 3, 1'b1, '{4'h6, 4'd6, 4'd3, 3'd2}, 1'b1);

    // Back-pressure: hold the result while a new sample waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run_frame(32'h4D3E_2F10, 8, 1'b0, '{4'h4, 4'd4, 4'd8, 3'd7}, 1'b1);
    hold_d   = out_data;
    hold_m   = out_mag;
    hold_c   = out_cnt;
    in_valid = 1'b1;
    in_data  = 4'h5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data_hold", 32'(out_data), 32'(hold_d));
      chk("bp_mag_hold", 32'(out_mag), 32'(hold_m));
      chk("bp_cnt_hold", 32'(out_cnt), 32'(hold_c));
    end
    out_ready = 1'b1;
    run_frame(32'h1111_1115, 8, 1'b0, '{4'h5, 4'd5, 4'd8, 3'd0}, 1'b1);

    @(posedge clk);
    #1;
    do_flush();
    for (int k = 0; k < 3; k++) begin
      chk("idle_flush_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    run_frame(32'h0000_4321, 4, 1'b0, '{4'h0, 4'd0, 4'd0, 3'd0}, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_mag", 32'(out_mag), 32'd0);
    chk("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
`ifdef ABSMAX_FRAME_SCHED_IDX_EN
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rerst_in_ready", 32'(in_ready), 32'd1);
    run_frame(32'h196B_4D2F, 8, 1'b0, '{4'h9, 4'd7, 4'd8, 3'd6}, 1'b1);

    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/absmax_frame_sched.md
# absmax_frame_sched

Frame scheduler for the signed absolute-maximum datapath. It accepts a stream of W-bit two's-complement samples over a valid/ready handshake and runs one shared magnitude comparator per accepted sample. It groups the samples into frames of FRAME_LEN, or shorter when flushed, and emits each frame's largest-magnitude sample with its original sign. It sits between a sample producer and any consumer of per-frame peak values.

## Interface
- W, 4: sample width in bits, two's complement.
- FRAME_LEN, 8: samples per full frame; must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  block can accept a sample.
- in_data  in  W  signed sample.
- flush  in  1  close the current frame early; sampled only in ACCUM.
- out_valid  out  1  frame result is valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  winning sample, original signed value.
- out_mag  out  W  winning magnitude, unsigned.
- out_cnt  out  $clog2(FRAME_LEN+1)  number of samples in the emitted frame.

## Operation
- The magnitude is |x| as a W-bit unsigned value. The most negative value, -2^(W-1), maps to 2^(W-1); for W=4, -8 gives 8. No saturation is needed.
- The FSM has three states: IDLE, ACCUM and EMIT.
- **IDLE**
  - in_ready=1.
  - On accept, the block loads best_data, best_mag and best_idx=0, sets cnt=1, and moves to ACCUM.
  - flush is ignored, because an empty frame produces no output.
- **ACCUM**
  - in_ready=1.
  - On accept, the comparator checks mag(in_data) against best_mag. best is replaced only when the new magnitude is strictly greater, so ties keep the earliest sample. cnt is incremented.
  - The state moves to EMIT when the accept brings cnt to FRAME_LEN, or on any cycle where flush=1.
  - When flush and accept happen in the same cycle, the sample is included first, then the frame closes.
- **EMIT**
  - in_ready=0 and out_valid=1.
  - out_data, out_mag and out_cnt are registered and held stable until out_ready=1.
  - On the out handshake the block clears cnt and returns to IDLE.
  - flush is ignored in EMIT.
- Frames never merge, and no sample is dropped or duplicated.

## Timing
- All outputs are 0 while rst is asserted, including in_ready. The state resets to IDLE, and in_ready=1 on the first edge after rst is released.
- Latency: out_valid rises on the clock edge that registers the frame-closing accept or flush.
- The result is visible one cycle after that accept or flush.
- Throughput: one sample per cycle inside a frame. There is at least one EMIT cycle between frames; this cycle is the back-pressure window.
- out_ready held low stalls the block indefinitely in EMIT, with all outputs held.
- If rst is asserted mid-frame or in EMIT, the partial frame and any pending result are discarded immediately. No output is produced for them.
- cnt wraps are impossible because the counter is bounded by FRAME_LEN.

## Configuration
- ABSMAX_FRAME_SCHED_IDX_EN
  - Defined: adds the output port out_idx, width $clog2(FRAME_LEN), giving the 0-based position of the winner within its frame. out_idx resets to 0 and is held with the other outputs in EMIT.
  - Undefined: the port and the best_idx register are absent. All other behaviour is identical.

## Structure
- Package absmax_pkg holds:
  - the state enum (IDLE, ACCUM, EMIT);
  - the default W;
  - the function abs_mag(x) returning the W-bit unsigned magnitude.
- Sub-module absmax_cmp:
  - combinational;
  - inputs: candidate sample and incumbent magnitude;
  - outputs: candidate magnitude and take_new (strict greater-than).
- The scheduler instantiates absmax_cmp exactly once; this is the shared datapath.

## Test plan
- Full frame, W=4, FRAME_LEN=8, out_ready=1: inputs 1,-3,2,5,-6,0,4,-2 -> out_data=-6 (4'b1010), out_mag=6, out_cnt=8, out_idx=4, one cycle after the 8th accept.
- Tie rule: 3,-3,3,2,1,0,0,0 -> out_data=3, out_idx=0. Most negative value: frame containing -8 and 7 -> out_data=-8, out_mag=8.
- Flush: 2,-5 then flush=1 with in_valid=0 -> out_cnt=2, out_data=-5. Flush together with a third sample 6 -> out_cnt=3, out_data=6.
- Back-pressure: out_ready=0 for 5 cycles in EMIT -> in_ready=0, outputs stable. Next frame starts only after the handshake.
- Flush in IDLE -> no out_valid.
- Reset mid-frame after 4 samples -> all outputs 0. The next 8 samples form a clean frame with out_cnt=8.
